// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    HALT  = 2'b11
  } state_e;

  // Instruction word loaded into IF/ID or ID/EX when a slot is squashed.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Counter register, cleared by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush/halt controller for the 5-stage core: merges hazard, branch
// flush, HALT and memory-busy conditions into PC/pipeline-register enables
// and squash controls, and keeps stall/flush statistics.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_in,
  input  logic             flush_in,
  input  logic             halt_in,
  input  logic             mem_stall,
  input  logic             resume,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_en,
  output logic             halted,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int RL_W = (MAX_STALL < 1) ? 1 : $clog2(MAX_STALL + 1);

  state_e          state_q, state_d;
  logic [RL_W-1:0] run_len_q, run_len_d;
  logic            timeout_q, timeout_d;
  logic            stall_inc, flush_inc;

  // Mealy next-state and control decode; priority mem_stall > flush > hazard > halt.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    run_len_d   = '0;
    timeout_d   = timeout_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (!rst) begin
      // Freeze the front end and squash everything while in reset.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      state_d     = RUN;
      timeout_d   = 1'b0;
    end else if (state_q == HALT) begin
      halted = 1'b1;
      if (mem_stall) begin
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
        exmem_en  = 1'b0;
        run_len_d = run_len_q;
      end else if (resume) begin
        state_d = RUN;
      end else begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_bubble = 1'b1;
      end
    end else if (mem_stall) begin
      // Whole pipe waits on data memory; nothing advances or is counted.
      pc_en     = 1'b0;
      ifid_en   = 1'b0;
      exmem_en  = 1'b0;
      run_len_d = run_len_q;
    end else if (flush_in) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      flush_inc   = 1'b1;
      state_d     = FLUSH;
    end else if ((state_q != FLUSH) && hazard_in) begin
      // ID holds a squashed slot after a flush, so hazards/HALT there are stale.
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      stall_inc   = 1'b1;
      state_d     = STALL;
      if (run_len_q == RL_W'(MAX_STALL)) begin
        timeout_d = 1'b1;
        run_len_d = run_len_q;
      end else begin
        run_len_d = run_len_q + RL_W'(1);
      end
    end else if ((state_q != FLUSH) && halt_in) begin
      // Let the HALT instruction itself move on into EX.
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      state_d = HALT;
    end else begin
      state_d = RUN;
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      run_len_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_timeout = timeout_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: a cycle model predicts outputs as
// stimulus is applied; predictions are popped and compared mid-cycle.
module tb_pipe_stall_ctrl;

  localparam int CNT_W     = 16;
  localparam int MAX_STALL = 3;
  localparam int M_RUN = 0, M_STALL = 1, M_FLUSH = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst, hazard_in, flush_in, halt_in, mem_stall, resume;
  logic pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, halted, stall_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  // Narrow-counter instance sharing the inputs, used to reach saturation quickly.
  logic sm_pc_en, sm_ifid_en, sm_ifid_flush, sm_idex_bubble, sm_exmem_en, sm_halted, sm_timeout;
  logic [3:0] sm_stall_cnt, sm_flush_cnt;

  pipe_stall_ctrl #(.CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
    .clk(clk), .rst(rst), .hazard_in(hazard_in), .flush_in(flush_in),
    .halt_in(halt_in), .mem_stall(mem_stall), .resume(resume),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_en(exmem_en), .halted(halted),
    .stall_timeout(stall_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stall_ctrl #(.CNT_W(4), .MAX_STALL(MAX_STALL)) dut_sm (
    .clk(clk), .rst(rst), .hazard_in(hazard_in), .flush_in(flush_in),
    .halt_in(halt_in), .mem_stall(mem_stall), .resume(resume),
    .pc_en(sm_pc_en), .ifid_en(sm_ifid_en), .ifid_flush(sm_ifid_flush),
    .idex_bubble(sm_idex_bubble), .exmem_en(sm_exmem_en), .halted(sm_halted),
    .stall_timeout(sm_timeout), .stall_cnt(sm_stall_cnt), .flush_cnt(sm_flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, hz, fl, ht, ms, rs;
  } stim_t;

  typedef struct packed {
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, halted, stall_timeout;
    logic [15:0] scnt, fcnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   m_state = M_RUN;
  int   m_run   = 0;
  logic m_to    = 1'b0;
  int   m_s     = 0;
  int   m_f     = 0;

  function automatic exp_t observed();
    exp_t o;
    o = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, halted, stall_timeout,
         stall_cnt, flush_cnt};
    return o;
  endfunction

  // Apply one cycle of stimulus, push the predicted outputs, advance the model.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; hazard_in = s.hz; flush_in = s.fl;
    halt_in = s.ht; mem_stall = s.ms; resume = s.rs;
    e = '0;
    e.stall_timeout = m_to;
    e.scnt = 16'(m_s);
    e.fcnt = 16'(m_f);
    if (!s.rst) begin
      e.ifid_flush = 1'b1; e.idex_bubble = 1'b1;
      m_state = M_RUN; m_run = 0; m_to = 1'b0; m_s = 0; m_f = 0;
    end else if (m_state == M_HALT) begin
      e.halted = 1'b1;
      if (s.ms) begin
        // everything frozen, resume ignored
      end else if (s.rs) begin
        e.pc_en = 1'b1; e.ifid_en = 1'b1; e.exmem_en = 1'b1;
        m_state = M_RUN; m_run = 0;
      end else begin
        e.idex_bubble = 1'b1; e.exmem_en = 1'b1; m_run = 0;
      end
    end else if (s.ms) begin
      // all enables low, nothing changes
    end else if (s.fl) begin
      e.pc_en = 1'b1; e.ifid_en = 1'b1; e.exmem_en = 1'b1;
      e.ifid_flush = 1'b1; e.idex_bubble = 1'b1;
      if (m_f < 65535) m_f++;
      m_state = M_FLUSH; m_run = 0;
    end else if (m_state != M_FLUSH && s.hz) begin
      e.idex_bubble = 1'b1; e.exmem_en = 1'b1;
      if (m_s < 65535) m_s++;
      if (m_run == MAX_STALL) m_to = 1'b1;
      else m_run++;
      m_state = M_STALL;
    end else if (m_state != M_FLUSH && s.ht) begin
      e.exmem_en = 1'b1;
      m_state = M_HALT; m_run = 0;
    end else begin
      e.pc_en = 1'b1; e.ifid_en = 1'b1; e.exmem_en = 1'b1;
      m_state = M_RUN; m_run = 0;
    end
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic test_reset();
    exp_t e;
    stim_t seq[$];
    // First reset cycle only initialises the DUT flops; its prediction is dropped.
    drive(6'b000000);
    e = sb_q.pop_front();
    seq.push_back(6'b000000);
    seq.push_back(6'b100000);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got %h required %h", i, observed(), e);
      end
    end
  endtask

  task automatic test_hazard_pulse();
    exp_t e;
    stim_t seq[$];
    seq = '{6'b000000, 6'b110000, 6'b100000};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL hazard_pulse cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({pc_en, stall_cnt, stall_timeout} !== {1'b1, 16'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL hazard_pulse_cnt: got pc_en=%b cnt=%0d to=%b required 1/1/0",
               pc_en, stall_cnt, stall_timeout);
    end
  endtask

  task automatic test_runaway();
    exp_t e;
    stim_t seq[$];
    seq.push_back(6'b000000);
    for (int k = 0; k < 5; k++) seq.push_back(6'b110000);
    seq.push_back(6'b100000);
    seq.push_back(6'b100000);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL runaway cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({stall_cnt, stall_timeout} !== {16'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL runaway_final: got cnt=%0d to=%b required 5/1", stall_cnt, stall_timeout);
    end
  endtask

  task automatic test_flush_hazard();
    exp_t e;
    stim_t seq[$];
    seq = '{6'b000000, 6'b111000, 6'b110000, 6'b101000, 6'b101000, 6'b100000};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL flush_hazard cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({flush_cnt, stall_cnt} !== {16'd3, 16'd0}) begin
      n_bad++;
      $display("FAIL flush_counts: got flush=%0d stall=%0d required 3/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_halt();
    exp_t e;
    stim_t seq[$];
    seq = '{6'b000000, 6'b100100, 6'b100000, 6'b100000, 6'b100000,
            6'b100011, 6'b100001, 6'b100000};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL halt cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({halted, pc_en} !== 2'b01) begin
      n_bad++;
      $display("FAIL halt_resume: got halted=%b pc_en=%b required 0/1", halted, pc_en);
    end
  endtask

  task automatic test_mem_stall();
    exp_t e;
    stim_t seq[$];
    seq = '{6'b000000, 6'b110000, 6'b110000, 6'b110010, 6'b110010,
            6'b110000, 6'b110000, 6'b100000};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL mem_stall cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({stall_cnt, stall_timeout} !== {16'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL mem_stall_hold: got cnt=%0d to=%b required 4/1", stall_cnt, stall_timeout);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    stim_t seq[$];
    seq.push_back(6'b000000);
    for (int k = 0; k < 18; k++) seq.push_back(6'b110000);
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL saturation cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({sm_stall_cnt, stall_cnt} !== {4'hF, 16'd17}) begin
      n_bad++;
      $display("FAIL sat_value: got narrow=%h wide=%0d required F/17", sm_stall_cnt, stall_cnt);
    end
    // Reset arrives in the middle of a stall run.
    seq = '{6'b010000, 6'b100000};
    foreach (seq[i]) begin
      drive(seq[i]);
      e = sb_q.pop_front();
      n_cmp++;
      if (observed() !== e) begin
        n_bad++;
        $display("FAIL mid_stall_reset cyc%0d: got %h required %h", i, observed(), e);
      end
    end
    n_cmp++;
    if ({pc_en, stall_cnt, flush_cnt, sm_stall_cnt, stall_timeout} !== {1'b1, 16'd0, 16'd0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_clears: got pc_en=%b s=%0d f=%0d narrow=%0d to=%b required 1/0/0/0/0",
               pc_en, stall_cnt, flush_cnt, sm_stall_cnt, stall_timeout);
    end
  endtask

  initial begin
    rst = 1'b0; hazard_in = 1'b0; flush_in = 1'b0;
    halt_in = 1'b0; mem_stall = 1'b0; resume = 1'b0;
    test_reset();
    test_hazard_pulse();
    test_runaway();
    test_flush_hazard();
    test_halt();
    test_mem_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
# pipe_stall_ctrl

Pipeline stall and flush controller: it takes the stall request from the hazard detector, combines it with the branch-flush, HALT and data-memory-busy conditions, and drives the PC and pipeline-register enables and squash controls. It sits between the hazard/branch logic and the PC, IF/ID, ID/EX and EX/MEM registers of the 5-stage core. It also keeps saturating stall and flush statistics and flags runaway stalls.

## Interface
- CNT_W, 16: width of the statistics counters.
- MAX_STALL, 3: longest legal run of consecutive hazard stall cycles.
- clk  in  1  the single clock.
- rst  in  1  reset, synchronous and active-low.
- hazard_in  in  1  stall request from the hazard detector (hazard_or_no).
- flush_in  in  1  taken branch or jump resolved in EX.
- halt_in  in  1  HALT decoded in ID.
- mem_stall  in  1  data memory not ready.
- resume  in  1  leave the halted state.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  load a NOP into IF/ID.
- idex_bubble  out  1  load a NOP into ID/EX.
- exmem_en  out  1  EX/MEM and MEM/WB enable.
- halted  out  1  core is halted.
- stall_timeout  out  1  sticky flag: runaway stall detected.
- stall_cnt  out  CNT_W  total hazard stall cycles.
- flush_cnt  out  CNT_W  total flush events.

## Operation
- FSM states: RUN, STALL, FLUSH, HALT.
- Control outputs are Mealy: a function of the current state and the current-cycle inputs.
- Input priority: mem_stall, then flush_in, then hazard_in, then halt_in.
- **Default (RUN, or STALL with nothing asserted):**
  - pc_en = ifid_en = exmem_en = 1; ifid_flush = idex_bubble = 0.
  - Next state RUN.
- **mem_stall = 1 (any state):**
  - All enables 0; ifid_flush = idex_bubble = 0.
  - State, run_len and all counters hold.
- **flush_in, in RUN, STALL or FLUSH:**
  - Enables 1; ifid_flush = idex_bubble = 1.
  - flush_cnt increments; next state FLUSH.
- **hazard_in, in RUN or STALL:**
  - pc_en = ifid_en = 0; idex_bubble = 1; exmem_en = 1.
  - stall_cnt increments; next state STALL.
  - If run_len == MAX_STALL, set stall_timeout; otherwise run_len increments.
- **halt_in, in RUN or STALL:**
  - pc_en = ifid_en = 0; idex_bubble = 0, so the HALT instruction moves on to EX.
  - Next state HALT.
- **FLUSH state:**
  - hazard_in and halt_in are ignored, because ID holds a squashed slot.
  - Otherwise default behaviour; next state RUN.
- **HALT state:**
  - pc_en = ifid_en = 0; idex_bubble = 1; exmem_en = 1; halted = 1.
  - flush_in, hazard_in and halt_in are ignored.
  - resume = 1 gives next state RUN, with default outputs in that resume cycle.
- **run_len** (0..MAX_STALL): cleared on any non-mem_stall cycle that is not an accepted hazard stall.
- **Counters:**
  - stall_cnt and flush_cnt saturate at all-ones and never wrap.
  - stall_timeout stays set until reset.

## Timing
- Control outputs have zero-cycle latency and respond in the same cycle as their inputs.
- State and counter updates take effect on the next rising clk edge.
- **While rst = 0:**
  - pc_en = ifid_en = exmem_en = 0; ifid_flush = idex_bubble = 1; halted = 0.
  - On the edge, state becomes RUN and run_len, both counters and stall_timeout clear.
- The first cycle after rst rises shows RUN default outputs.
- Reset asserted mid-stall or mid-halt overrides everything in the same cycle.
- flush_in and hazard_in together: the flush wins, no stall is counted, and run_len clears.
- mem_stall during HALT: all enables 0, halted stays 1, and resume is ignored that cycle.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the state encoding: RUN = 2'b00, STALL = 2'b01, FLUSH = 2'b10, HALT = 2'b11;
  - the NOP instruction constant used by ifid_flush and idex_bubble.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, count) is instantiated twice, once for stall_cnt and once for flush_cnt.

## Test plan
- Reset → pulse hazard_in for 1 cycle → in that cycle pc_en = 0, ifid_en = 0, idex_bubble = 1; next cycle all enables 1; stall_cnt = 1, stall_timeout = 0.
- hazard_in held for 5 cycles with MAX_STALL = 3 → stall_cnt = 5; stall_timeout becomes 1 after the edge ending the 4th stall cycle and stays 1 after hazard_in drops.
- flush_in and hazard_in in the same cycle, then hazard_in alone the next cycle → ifid_flush = idex_bubble = 1; second cycle shows default outputs (FLUSH ignores hazard); flush_cnt = 1, stall_cnt = 0.
- halt_in, then 3 idle cycles, then resume → halt cycle has pc_en = 0, idex_bubble = 0; halted = 1 for 3 cycles; then RUN with pc_en = 1.
- mem_stall held 2 cycles during STALL with hazard_in asserted → all enables 0 and stall_cnt unchanged; state STALL is preserved afterwards.
- Force stall_cnt to 16'hFFFE, then 3 hazard cycles → stall_cnt reads FFFF and holds there; rst low mid-stall → next cycle shows RUN outputs and all counters 0.
